// File: rtl/countdown_timer.sv
// MM:SS countdown/count-up timer with pushbutton control and 7-segment output.
// Digits are BCD registers advanced by a one-second prescaler tick.
module countdown_timer #(
    parameter int TICK_CYCLES    = 50000000,
    parameter int MAX_MIN        = 59,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [2:0]  KEY,
    input  logic [15:0] SW,
    output logic        MODE_DOWN,
    output logic        ALARM,
    output logic [0:6]  HEX0,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX3
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_U = 4'(MAX_MIN % 10);
    localparam logic [6:0]    MAX_V = 7'(MAX_MIN);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [2:0]    sync1, sync2, sync3, press;
    logic          clr, start, mode;
    logic [PW-1:0] presc;
    logic          blank, hide, wrap, tick;
    logic          at_zero, at_one;
    logic [3:0]    sec_u, sec_t, min_u, min_t;
    logic [3:0]    cs_u, cs_t, cm_u, cm_t;
    logic [3:0]    ld_su, ld_st, ld_mu, ld_mt;
    logic [3:0]    nx_su, nx_st, nx_mu, nx_mt;
    logic [6:0]    cm_v;

    // Falling edge of the synchronised pin; clear beats start beats mode.
    assign press   = sync3 & ~sync2;
    assign clr     = press[1];
    assign start   = press[0] & ~press[1];
    assign mode    = press[2] & ~press[1] & ~press[0];
    assign wrap    = (presc == LAST);
    assign tick    = (state == RUN) && wrap;
    assign at_zero = ({min_t, min_u, sec_t, sec_u} == 16'h0000);
    assign at_one  = ({min_t, min_u, sec_t, sec_u} == 16'h0001);
    assign hide    = (state == DONE) && blank;

    always_comb begin
        cs_u = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];
        cs_t = (SW[7:4] > 4'd5) ? 4'd5 : SW[7:4];
        cm_u = (SW[11:8] > 4'd9) ? 4'd9 : SW[11:8];
        cm_t = (SW[15:12] > 4'd9) ? 4'd9 : SW[15:12];
        cm_v = 7'(cm_t) * 7'd10 + 7'(cm_u);
        if (cm_v > MAX_V) begin
            cm_t = MAX_T;
            cm_u = MAX_U;
        end
        ld_su = MODE_DOWN ? cs_u : 4'd0;
        ld_st = MODE_DOWN ? cs_t : 4'd0;
        ld_mu = MODE_DOWN ? cm_u : 4'd0;
        ld_mt = MODE_DOWN ? cm_t : 4'd0;
    end

    always_comb begin
        nx_su = sec_u;
        nx_st = sec_t;
        nx_mu = min_u;
        nx_mt = min_t;
        if (MODE_DOWN) begin
            if (sec_u != 4'd0) begin
                nx_su = sec_u - 4'd1;
            end else begin
                nx_su = 4'd9;
                if (sec_t != 4'd0) begin
                    nx_st = sec_t - 4'd1;
                end else begin
                    nx_st = 4'd5;
                    if (min_u != 4'd0) begin
                        nx_mu = min_u - 4'd1;
                    end else begin
                        nx_mu = 4'd9;
                        nx_mt = min_t - 4'd1;
                    end
                end
            end
        end else begin
            if (sec_u != 4'd9) begin
                nx_su = sec_u + 4'd1;
            end else begin
                nx_su = 4'd0;
                if (sec_t != 4'd5) begin
                    nx_st = sec_t + 4'd1;
                end else begin
                    nx_st = 4'd0;
                    if (min_t == MAX_T && min_u == MAX_U) begin
                        nx_mu = 4'd0;
                        nx_mt = 4'd0;
                    end else if (min_u != 4'd9) begin
                        nx_mu = min_u + 4'd1;
                    end else begin
                        nx_mu = 4'd0;
                        nx_mt = min_t + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            MODE_DOWN <= 1'b0;
            ALARM     <= 1'b0;
            sync1     <= 3'b111;
            sync2     <= 3'b111;
            sync3     <= 3'b111;
            presc     <= '0;
            blank     <= 1'b0;
            sec_u     <= 4'd0;
            sec_t     <= 4'd0;
            min_u     <= 4'd0;
            min_t     <= 4'd0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            sync3 <= sync2;
            unique case (state)
                IDLE: begin
                    presc <= '0;
                    blank <= 1'b0;
                    if (clr) begin
                        sec_u <= ld_su;
                        sec_t <= ld_st;
                        min_u <= ld_mu;
                        min_t <= ld_mt;
                    end else if (start) begin
                        if (MODE_DOWN && at_zero) begin
                            state <= DONE;
                            ALARM <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else if (mode) begin
                        MODE_DOWN <= ~MODE_DOWN;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= IDLE;
                        presc <= '0;
                        sec_u <= ld_su;
                        sec_t <= ld_st;
                        min_u <= ld_mu;
                        min_t <= ld_mt;
                    end else begin
                        presc <= wrap ? '0 : presc + PW'(1);
                        if (tick) begin
                            sec_u <= nx_su;
                            sec_t <= nx_st;
                            min_u <= nx_mu;
                            min_t <= nx_mt;
                        end
                        // Reaching zero wins over a simultaneous pause.
                        if (tick && MODE_DOWN && at_one) begin
                            state <= DONE;
                            ALARM <= 1'b1;
                            blank <= 1'b0;
                        end else if (start) begin
                            state <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (clr) begin
                        state <= IDLE;
                        presc <= '0;
                        sec_u <= ld_su;
                        sec_t <= ld_st;
                        min_u <= ld_mu;
                        min_t <= ld_mt;
                    end else if (start) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    if (clr || start) begin
                        state <= IDLE;
                        ALARM <= 1'b0;
                        blank <= 1'b0;
                        presc <= '0;
                        sec_u <= ld_su;
                        sec_t <= ld_st;
                        min_u <= ld_mu;
                        min_t <= ld_mt;
                    end else begin
                        presc <= wrap ? '0 : presc + PW'(1);
                        if (wrap) blank <= ~blank;
                    end
                end
            endcase
        end
    end

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [0:6] drive(input logic [3:0] d, input logic off);
        logic [0:6] s;
        s = off ? 7'b0000000 : seg7(d);
        return HEX_ACTIVE_LOW ? ~s : s;
    endfunction

    assign HEX0 = drive(sec_u, hide);
    assign HEX1 = drive(sec_t, hide);
    assign HEX2 = drive(min_u, hide);
    assign HEX3 = drive(min_t, hide);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random keys,
// compared each cycle against a seconds-based reference model.
module tb_countdown_timer;

    localparam int T    = 4;
    localparam int MAXM = 59;
    localparam int WRAP = (MAXM + 1) * 60;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  key = 3'b111;
    logic [15:0] sw = 16'h0000;
    logic        mode_down, alarm;
    logic [0:6]  hex0, hex1, hex2, hex3;
    logic [29:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;
    logic [29:0] sb[$];

    int   m_state, m_total, m_pre, m_done_cyc;
    bit   m_down;
    logic [2:0] m_h0, m_h1, m_h2;

    countdown_timer #(
        .TICK_CYCLES(T),
        .MAX_MIN(MAXM),
        .HEX_ACTIVE_LOW(1'b1)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .KEY(key),
        .SW(sw),
        .MODE_DOWN(mode_down),
        .ALARM(alarm),
        .HEX0(hex0),
        .HEX1(hex1),
        .HEX2(hex2),
        .HEX3(hex3)
    );

    assign dut_vec = {alarm, mode_down, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    function automatic logic [0:6] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [29:0] disp(input bit al, input bit md,
                                         input int mm, input int ss,
                                         input bit bl);
        logic [0:6] h [4];
        int d [4];
        d[0] = ss % 10;
        d[1] = ss / 10;
        d[2] = mm % 10;
        d[3] = mm / 10;
        for (int i = 0; i < 4; i++)
            h[i] = bl ? 7'b1111111 : ~seg(d[i]);
        return {al, md, h[3], h[2], h[1], h[0]};
    endfunction

    task automatic check_vec(input string name, input logic [29:0] got,
                             input logic [29:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic chk(input string name, input bit al, input bit md,
                       input int mm, input int ss, input bit bl);
        check_vec(name, dut_vec, disp(al, md, mm, ss, bl));
    endtask

    function automatic int preset_secs(input logic [15:0] v);
        int mt, mu, st, su, m;
        mt = (v[15:12] > 9) ? 9 : int'(v[15:12]);
        mu = (v[11:8] > 9) ? 9 : int'(v[11:8]);
        st = (v[7:4] > 5) ? 5 : int'(v[7:4]);
        su = (v[3:0] > 9) ? 9 : int'(v[3:0]);
        m = mt * 10 + mu;
        if (m > MAXM) m = MAXM;
        return m * 60 + st * 10 + su;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_total = 0;
        m_pre = 0;
        m_done_cyc = 0;
        m_down = 0;
        m_h0 = 3'b111;
        m_h1 = 3'b111;
        m_h2 = 3'b111;
    endtask

    function automatic logic [29:0] model_out();
        bit bl;
        bl = (m_state == S_DONE) && (((m_done_cyc / T) % 2) == 1);
        return disp(m_state == S_DONE, m_down, m_total / 60, m_total % 60, bl);
    endfunction

    task automatic go_idle();
        m_state = S_IDLE;
        m_pre = 0;
        m_total = m_down ? preset_secs(sw) : 0;
    endtask

    task automatic go_done();
        m_state = S_DONE;
        m_pre = 0;
        m_done_cyc = 0;
    endtask

    // A pin low at sample n-2 and high at n-3 acts at edge n.
    task automatic model_step();
        logic [2:0] pr;
        bit c, s, md, tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pr = m_h2 & ~m_h1;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = key;
        c = pr[1];
        s = pr[0] && !c;
        md = pr[2] && !pr[1] && !pr[0];
        case (m_state)
            S_IDLE: begin
                if (c) go_idle();
                else if (s) begin
                    if (m_down && m_total == 0) go_done();
                    else m_state = S_RUN;
                end else if (md) m_down = !m_down;
            end
            S_RUN: begin
                if (c) go_idle();
                else begin
                    tk = (m_pre == T - 1);
                    m_pre = (m_pre + 1) % T;
                    if (tk) begin
                        if (m_down) begin
                            m_total = m_total - 1;
                            if (m_total == 0) go_done();
                        end else begin
                            m_total = (m_total + 1) % WRAP;
                        end
                    end
                    if (m_state == S_RUN && s) m_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (c) go_idle();
                else if (s) m_state = S_RUN;
            end
            default: begin
                if (c || s) go_idle();
                else m_done_cyc++;
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        sb.push_back(model_out());
    endtask

    task automatic press(input logic [2:0] mask);
        key = key & ~mask;
        cycle();
        key = key | mask;
        cycle();
        cycle();
    endtask

    // Called at posedge+1; drops reset between edges.
    task automatic async_rst();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, 0, 0, 0, 0);
        model_reset();
        sb.delete();
        sb.push_back(model_out());
        cycle();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [29:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_vec("cycle", dut_vec, e);
        end
    end

    initial begin
        logic [2:0] k;
        model_reset();
        cycle();
        cycle();
        chk("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle();

        press(3'b001);
        repeat (3) cycle();
        chk("pre_tick", 0, 0, 0, 0, 0);
        cycle();
        chk("first_tick", 0, 0, 0, 1, 0);
        repeat (236) cycle();
        chk("run_240", 0, 0, 1, 0, 0);
        press(3'b010);
        chk("clear_up", 0, 0, 0, 0, 0);

        press(3'b100);
        chk("mode_down", 0, 1, 0, 0, 0);
        sw = 16'h0002;
        press(3'b010);
        chk("reload_down", 0, 1, 0, 2, 0);
        press(3'b001);
        repeat (4) cycle();
        chk("down_0001", 0, 1, 0, 1, 0);
        repeat (4) cycle();
        chk("done", 1, 1, 0, 0, 0);
        repeat (4) cycle();
        chk("blink_off", 1, 1, 0, 0, 1);
        repeat (4) cycle();
        chk("blink_on", 1, 1, 0, 0, 0);
        press(3'b001);
        chk("done_exit", 0, 1, 0, 2, 0);

        sw = 16'hF9F9;
        press(3'b010);
        chk("clamp", 0, 1, 59, 59, 0);
        sw = 16'h0000;
        press(3'b010);
        press(3'b001);
        chk("zero_start", 1, 1, 0, 0, 0);
        press(3'b010);
        chk("zero_exit", 0, 1, 0, 0, 0);

        sw = 16'h5958;
        press(3'b010);
        press(3'b100);
        chk("mode_up", 0, 0, 59, 58, 0);
        press(3'b001);
        repeat (4) cycle();
        chk("up_5959", 0, 0, 59, 59, 0);
        repeat (3) cycle();
        press(3'b001);
        chk("wrap_pause", 0, 0, 0, 0, 0);
        repeat (5) cycle();
        chk("pause_hold", 0, 0, 0, 0, 0);
        press(3'b001);
        cycle();
        chk("resume_1", 0, 0, 0, 0, 0);
        cycle();
        chk("resume_2", 0, 0, 0, 1, 0);
        cycle();
        press(3'b011);
        chk("tick_clear", 0, 0, 0, 0, 0);
        repeat (8) cycle();
        chk("idle_hold", 0, 0, 0, 0, 0);

        press(3'b001);
        cycle();
        press(3'b001);
        chk("tick_pause", 0, 0, 0, 1, 0);
        repeat (6) cycle();
        chk("pause_hold2", 0, 0, 0, 1, 0);
        press(3'b001);
        repeat (4) cycle();
        chk("resume_tick", 0, 0, 0, 2, 0);
        repeat (2) cycle();
        async_rst();

        for (int i = 0; i < 3000; i++) begin
            k = 3'b111;
            if ($urandom_range(0, 19) == 0) k[0] = 1'b0;
            if ($urandom_range(0, 79) == 0) k[1] = 1'b0;
            if ($urandom_range(0, 11) == 0) k[2] = 1'b0;
            key = k;
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    sw = 16'($urandom);
                else
                    sw = {11'h000, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15))};
            end
            cycle();
            if ($urandom_range(0, 1199) == 0) async_rst();
        end

        key = 3'b111;
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
